mult_32_bit_seq: RTL and testbench
==================================

# mult_32_bit_seq

Multi-cycle 32x32 shift-add multiplier for the MIPS MULT/MULTU path, producing a 64-bit product split into HI and LO. It is the additive counterpart of the combinational 32-bit subtractor and reuses the same 32-bit add datapath, iterated once per multiplier bit. It sits beside the ALU and feeds the HI/LO registers. The control stalls issue while `busy` is high.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `clk` rising edge.
- `start` in 1: request a multiply; accepted only in IDLE.
- `signed_op` in 1: 1 = MULT (two's complement), 0 = MULTU; captured with the operands.
- `a` in 32: multiplicand; captured on accept.
- `b` in 32: multiplier; captured on accept.
- `busy` out 1: high from the accept edge until the completion edge.
- `done` out 1: one-cycle pulse, result valid.
- `hi` out 32: upper product word; held until the next completion.
- `lo` out 32: lower product word; held until the next completion.

## Operation
- States:
  - IDLE
  - CALC (32 iterations, 6-bit counter 0..31)
  - FIX (sign correction and output load)
- IDLE with `start`=1:
  - capture magnitudes |a| and |b| when `signed_op`=1 (raw values otherwise)
  - capture `neg` = `signed_op` & (a[31] ^ b[31])
  - clear the 64-bit accumulator
  - counter = 0, `busy` = 1, go to CALC
- Magnitude of 0x80000000 is 2^31, representable as 32-bit unsigned; no special case.
- CALC, each cycle:
  - if the multiplier LSB is 1, add the multiplicand to the accumulator upper half via the 32-bit adder; the carry-out becomes bit 63 of the shifted result
  - shift the accumulator and the multiplier right by 1
  - counter++
  - after the counter=31 iteration, go to FIX
- FIX:
  - result = `neg` ? 64-bit two's-complement negate of the accumulator : accumulator
  - hi = result[63:32], lo = result[31:0]
  - `done` = 1, `busy` = 0, go to IDLE
- `start` while `busy`=1 is ignored; no queueing, and the operands are not re-sampled.
- `a`, `b` and `signed_op` may change freely after the accept edge.
- `done` is asserted only in the cycle after the FIX edge; it is 0 otherwise.
- Reset, including mid-operation, sets:
  - state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0
  - the accumulator and counter are cleared
  - the in-flight result is discarded; there is no partial write of hi/lo.
- `reset` and `start` high in the same cycle: reset wins and the request is dropped.

## Timing
- Accept edge k: `busy` is high from cycle k+1.
- CALC edges: k+1 .. k+32.
- FIX edge: k+33. `done`=1 and `hi`/`lo` are valid during cycle k+34; `busy`=0 in cycle k+34.
- Total latency: 34 cycles from the start edge to `done`, fixed and independent of operand values and sign.
- Back-to-back operation: `start` high during the `done` cycle (state IDLE) is accepted at that edge.
  - Throughput: one result per 34 cycles.
- `hi`/`lo` change only on the FIX edge or on reset.
- The combinational path per cycle is one 32-bit add plus a mux; there is no 64-bit add except the FIX negate.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset` 2 cycles, `start`=0.
  - Required response: `hi`=0, `lo`=0, `busy`=0, `done`=0 throughout.
- Unsigned maximum:
  - Stimulus: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required response: `done` exactly 34 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed signs:
  - MULT a=7, b=0xFFFFFFFD (-3) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULT a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Signed extreme:
  - MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
  - MULT a=0x12345678, b=0 → hi=0, lo=0.
- Start while busy and back-to-back:
  - Stimulus: pulse `start` with new operands at cycle k+10.
  - Required response: ignored; the first result is unchanged.
  - Then assert `start` (MULTU 3 x 5) in the `done` cycle.
  - Required response: second `done` 34 cycles later, hi=0, lo=15.
- Reset mid-operation:
  - Stimulus: assert `reset` at cycle k+20 of a MULTU 0xFFFFFFFF x 2.
  - Required response: next cycle `busy`=0, hi=lo=0, and no `done` pulse follows.
  - Then a fresh MULTU 6 x 7 gives lo=42.

Source files
------------

// File: rtl/mult_32_bit_seq.sv
// Sequential 32x32 shift-add multiplier for MULT/MULTU; one 32-bit add per
// multiplier bit, sign fixed up once at the end, product delivered as hi/lo.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last product
// CALC  | 32 shift-add iterations on operand magnitudes
// FIX   | optional 64-bit negate, load hi/lo, pulse done
module mult_32_bit_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic        neg;

  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [63:0] result;

  // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
  always_comb begin
    a_mag  = (signed_op && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (signed_op && b[31]) ? (~b + 32'd1) : b;
    sum    = {1'b0, acc[63:32]} + {1'b0, (mplier[0] ? mcand : 32'd0)};
    result = neg ? (~acc + 64'd1) : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_op & (a[31] ^ b[31]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          // adder carry-out lands in bit 63 as the accumulator shifts right
          acc    <= {sum, acc[31:1]};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 6'd1;
        end
        FIX: begin
          hi   <= result[63:32];
          lo   <= result[31:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_32_bit_seq.sv
// Scoreboard bench for mult_32_bit_seq: expected products and accept cycles
// are queued at accept and compared when done pulses.
module tb_mult_32_bit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [63:0] prod;
    int unsigned acc_cyc;
  } exp_t;
  exp_t q[$];

  mult_32_bit_seq dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s) return sx * sy;
    return {32'd0, x} * {32'd0, y};
  endfunction

  // called at a negedge; returns at the negedge after the accept edge
  task automatic mult(input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic [63:0] e);
    exp_t item;
    start = 1'b1; signed_op = s; a = x; b = y;
    @(posedge clk);
    #1;
    item.prod = e;
    item.acc_cyc = cyc;
    q.push_back(item);
    start = 1'b0; signed_op = ~s; a = $urandom; b = $urandom;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 60) chk("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 80; n++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (n == 80) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", {hi, lo}, e.prod);
        chk("latency", 64'(cyc - e.acc_cyc), 64'd33);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] rx, ry;
    logic        rs;

    repeat (2) begin
      @(negedge clk);
      chk("reset_state", {hi, lo}, 64'd0);
      chk("reset_flags", {62'd0, busy, done}, 64'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_flags", {62'd0, busy, done}, 64'd0);
    end

    mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait_empty();
    mult(1'b1, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB);
    wait_empty();
    mult(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    wait_empty();
    mult(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    wait_empty();
    mult(1'b1, 32'h12345678, 32'd0, 64'd0);
    wait_empty();
    chk("hold_after_done", {hi, lo}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      rs = 1'(i);
      rx = $urandom;
      ry = $urandom;
      mult(rs, rx, ry, model(rs, rx, ry));
      wait_empty();
    end

    // start while busy is ignored, then back-to-back in the done cycle
    mult(1'b1, 32'hFFFF0000, 32'd12345, model(1'b1, 32'hFFFF0000, 32'd12345));
    repeat (8) @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'd99; b = 32'd77;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    mult(1'b0, 32'd3, 32'd5, 64'd15);
    wait_empty();

    // reset mid-operation discards the result
    mult(1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    repeat (18) @(negedge clk);
    q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    chk("midreset_no_done_hilo", {hi, lo}, 64'd0);
    mult(1'b0, 32'd6, 32'd7, 64'd42);
    wait_empty();

    // reset and start together: request dropped
    reset = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("reset_start_hilo", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

endmodule
